// File: rtl/rng_spawn_requester.sv
// rng_spawn_requester
//   Requests random numbers from the rng and keeps a small FIFO of spawn
//   coordinates topped up for the enemy/object spawn controller. Each request
//   is a one-cycle pulse on rng_trigger. The block then waits for a rising
//   edge on rng_ready and captures rng_num. The sample is split into x (upper
//   nibble) and y (lower nibble). Samples whose row is outside the playfield
//   are counted and discarded.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous active-low reset
//   enable       in   allow new requests to the generator
//   rng_trigger  out  to rng.trigger; its falling edge requests a number
//   rng_ready    in   from rng.ready
//   rng_num      in   from rng.rdm_num
//   spawn_valid  out  FIFO head holds a coordinate
//   spawn_x      out  head x
//   spawn_y      out  head y
//   spawn_ack    in   pops the head when spawn_valid is high
//   fill_count   out  number of stored entries
//   timeout_err  out  one-cycle pulse when a request gets no answer in time
//   drop_count   out  saturating count of rejected samples
module rng_spawn_requester #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15,
  parameter int Y_MAX      = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       rng_trigger,
  input  logic       rng_ready,
  input  logic [7:0] rng_num,
  output logic       spawn_valid,
  output logic [3:0] spawn_x,
  output logic [3:0] spawn_y,
  input  logic       spawn_ack,
  output logic [3:0] fill_count,
  output logic       timeout_err,
  output logic [7:0] drop_count
);

  localparam int         PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] Y_LIM = 4'(Y_MAX);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  localparam logic [3:0] FULL_CNT = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       timer;
  logic             rng_ready_d;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic rdy_rise;
  logic y_ok;
  logic push;
  logic pop;
  logic full;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The row nibble is compared unsigned; x needs no check.
  function automatic logic row_legal(input logic [7:0] num);
    return num[3:0] <= Y_LIM;
  endfunction

  assign rdy_rise = rng_ready & ~rng_ready_d;
  assign y_ok     = row_legal(rng_num);
  assign push     = (state == S_WAIT) && rdy_rise && y_ok;
  assign full     = (fill_count == FULL_CNT);

  assign spawn_valid = (fill_count != 4'd0);
  assign pop         = spawn_valid & spawn_ack;

  // The head is shown straight from storage. It is forced to zero while the
  // FIFO is empty, so stale or unwritten entries never reach the outputs.
  assign spawn_x = spawn_valid ? mem[rd_ptr][7:4] : 4'd0;
  assign spawn_y = spawn_valid ? mem[rd_ptr][3:0] : 4'd0;

  // Request FSM: IDLE -> TRIG (one cycle of trigger) -> WAIT -> IDLE.
  // Requests are only issued when the FIFO is not full. Only one request is
  // ever in flight, so a push can never land on a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      rng_trigger <= 1'b0;
      timer       <= 8'd0;
      timeout_err <= 1'b0;
      drop_count  <= 8'd0;
      rng_ready_d <= 1'b0;
    end else begin
      rng_ready_d <= rng_ready;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && !full) begin
            state       <= S_TRIG;
            rng_trigger <= 1'b1;
          end
        end
        S_TRIG: begin
          state       <= S_WAIT;
          rng_trigger <= 1'b0;
          timer       <= 8'd0;
        end
        S_WAIT: begin
          if (rdy_rise) begin
            if (!y_ok) drop_count <= sat_inc(drop_count);
            state <= S_IDLE;
          end else if (timer == TO_LIM) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
          state       <= S_IDLE;
          rng_trigger <= 1'b0;
        end
      endcase
    end
  end

  // FIFO control. Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill_count <= fill_count + 4'd1;
        2'b01:   fill_count <= fill_count - 4'd1;
        default: fill_count <= fill_count;
      endcase
    end
  end

  // FIFO storage. The data path is not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rng_num;
  end

endmodule

// File: tb/tb_rng_spawn_requester.sv
module tb_rng_spawn_requester;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       rng_trigger;
  logic       rng_ready = 1'b0;
  logic [7:0] rng_num = 8'd0;
  logic       spawn_valid;
  logic [3:0] spawn_x;
  logic [3:0] spawn_y;
  logic       spawn_ack = 1'b0;
  logic [3:0] fill_count;
  logic       timeout_err;
  logic [7:0] drop_count;

  int checks = 0;
  int failures = 0;

  rng_spawn_requester #(
    .FIFO_DEPTH(4),
    .TIMEOUT(15),
    .Y_MAX(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .rng_trigger(rng_trigger),
    .rng_ready(rng_ready),
    .rng_num(rng_num),
    .spawn_valid(spawn_valid),
    .spawn_x(spawn_x),
    .spawn_y(spawn_y),
    .spawn_ack(spawn_ack),
    .fill_count(fill_count),
    .timeout_err(timeout_err),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) on falling clock edges until rng_trigger is seen high.
  // Returns at the falling edge inside the trigger cycle (cycle T).
  task automatic wait_trig(output int n);
    n = 0;
    while (rng_trigger !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rng_trigger !== 1'b1) check("trigger_seen", 32'd0, 32'd1);
  endtask

  // Nominal generator: ready rises in cycle T+3 together with the number.
  // Called 'skip' falling edges after T. Returns at the falling edge of T+4.
  task automatic respond(input logic [7:0] num, input bit give_ready, input bit ack_at_push,
                         input int skip, output bit v_t3);
    repeat (3 - skip) @(negedge clk);
    v_t3      = spawn_valid;
    rng_num   = num;
    rng_ready = give_ready;
    spawn_ack = ack_at_push;
    @(negedge clk);
    rng_ready = 1'b0;
    spawn_ack = 1'b0;
  endtask

  task automatic serve(input logic [7:0] num, input bit ack_at_push, output bit v_t3, output int n);
    enable = 1'b1;
    wait_trig(n);
    enable = 1'b0;
    respond(num, 1'b1, ack_at_push, 0, v_t3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit         v;
    int         n;
    int         trig_cnt;
    logic [7:0] nb;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_trigger", 32'(rng_trigger), 32'd0);
    check("rst_valid",   32'(spawn_valid), 32'd0);
    check("rst_x",       32'(spawn_x),     32'd0);
    check("rst_y",       32'(spawn_y),     32'd0);
    check("rst_fill",    32'(fill_count),  32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_drop",    32'(drop_count),  32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_no_enable", 32'(rng_trigger), 32'd0);

    // First request: 8'h5A -> (5,10), latency checks
    enable = 1'b1;
    wait_trig(n);
    check("trig_latency", 32'(n), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check("trig_one_cycle", 32'(rng_trigger), 32'd0);
    respond(8'h5A, 1'b1, 1'b0, 1, v);
    check("valid_t3", 32'(v), 32'd0);
    check("valid_t4", 32'(spawn_valid), 32'd1);
    check("x_5a", 32'(spawn_x), 32'd5);
    check("y_5a", 32'(spawn_y), 32'd10);
    check("fill_5a", 32'(fill_count), 32'd1);

    // Out-of-field row: 8'h3E is dropped
    serve(8'h3E, 1'b0, v, n);
    check("drop_3e", 32'(drop_count), 32'd1);
    check("fill_3e", 32'(fill_count), 32'd1);
    check("head_3e", 32'(spawn_x), 32'd5);

    // Pop (5,10), then an ack on an empty FIFO is ignored
    spawn_ack = 1'b1;
    @(negedge clk);
    spawn_ack = 1'b0;
    check("pop_fill", 32'(fill_count), 32'd0);
    check("pop_valid", 32'(spawn_valid), 32'd0);
    spawn_ack = 1'b1;
    @(negedge clk);
    spawn_ack = 1'b0;
    check("empty_ack_fill", 32'(fill_count), 32'd0);

    // Fill to full with 11,22,33,44
    for (int i = 0; i < 4; i++) begin
      nb = 8'((i + 1) * 17);
      serve(nb, 1'b0, v, n);
      if (i == 0) check("retrig_after_drop", 32'(n), 32'd1);
    end
    check("full_fill", 32'(fill_count), 32'd4);
    check("full_head_x", 32'(spawn_x), 32'd1);

    // No further trigger while full
    enable = 1'b1;
    trig_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rng_trigger) trig_cnt++;
    end
    enable = 1'b0;
    check("no_trig_full", 32'(trig_cnt), 32'd0);

    // Pop order 1,2,3,4
    for (int i = 0; i < 4; i++) begin
      check("pop_order_x", 32'(spawn_x), 32'(i + 1));
      check("pop_order_y", 32'(spawn_y), 32'(i + 1));
      spawn_ack = 1'b1;
      @(negedge clk);
      spawn_ack = 1'b0;
    end
    check("drained_fill", 32'(fill_count), 32'd0);

    // Timeout: 16 WAIT cycles, pulse in T+17, retry trigger in T+18
    enable = 1'b1;
    wait_trig(n);
    repeat (16) @(negedge clk);
    check("to_not_yet", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("to_pulse", 32'(timeout_err), 32'd1);
    check("to_fill", 32'(fill_count), 32'd0);
    check("to_trig_low", 32'(rng_trigger), 32'd0);
    @(negedge clk);
    check("to_pulse_end", 32'(timeout_err), 32'd0);
    check("to_retry_trig", 32'(rng_trigger), 32'd1);
    enable = 1'b0;
    respond(8'h55, 1'b1, 1'b0, 0, v);
    check("retry_fill", 32'(fill_count), 32'd1);
    check("retry_x", 32'(spawn_x), 32'd5);

    // Push and pop in the same cycle, across pointer wrap
    serve(8'h66, 1'b0, v, n);
    check("two_fill", 32'(fill_count), 32'd2);
    serve(8'h77, 1'b1, v, n);
    check("pushpop_fill", 32'(fill_count), 32'd2);
    check("pushpop_head", 32'(spawn_x), 32'd6);
    spawn_ack = 1'b1;
    @(negedge clk);
    spawn_ack = 1'b0;
    check("wrap_head", 32'(spawn_x), 32'd7);
    check("wrap_fill", 32'(fill_count), 32'd1);

    // Reset during WAIT, then a late ready rise
    enable = 1'b1;
    wait_trig(n);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    respond(8'h12, 1'b1, 1'b0, 2, v);
    check("mid_rst_fill", 32'(fill_count), 32'd0);
    check("mid_rst_valid", 32'(spawn_valid), 32'd0);
    check("mid_rst_trig", 32'(rng_trigger), 32'd0);
    check("mid_rst_drop", 32'(drop_count), 32'd0);
    check("mid_rst_x", 32'(spawn_x), 32'd0);
    check("mid_rst_y", 32'(spawn_y), 32'd0);
    @(negedge clk);
    check("mid_rst_timeout", 32'(timeout_err), 32'd0);
    check("mid_rst_fill2", 32'(fill_count), 32'd0);

    // Row boundary: y=12 kept, y=13 dropped
    serve(8'hFC, 1'b0, v, n);
    check("ymax_fill", 32'(fill_count), 32'd1);
    check("ymax_x", 32'(spawn_x), 32'd15);
    check("ymax_y", 32'(spawn_y), 32'd12);
    check("ymax_drop", 32'(drop_count), 32'd0);
    serve(8'h0D, 1'b0, v, n);
    check("y13_drop", 32'(drop_count), 32'd1);
    check("y13_fill", 32'(fill_count), 32'd1);

    // Drop counter saturates at 255
    for (int i = 0; i < 260; i++) serve(8'hFF, 1'b0, v, n);
    check("drop_sat", 32'(drop_count), 32'd255);
    check("sat_fill", 32'(fill_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
